imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator in the decode stage.
- Takes one instruction per valid/ready handshake and emits a sign/zero-extended immediate of configurable width, one cycle after acceptance.
- Adds a PREFIX mode: prefix instructions accumulate upper immediate bits, which are concatenated onto the next immediate. This gives constants wider than 8 bits without changing the instruction width.

---
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction input channel and
// immediate output channel, both valid/ready.
interface imm_gen_pipe_if #(
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic [2:0]         imm_src;
  logic               out_valid;
  logic               out_ready;
  logic [IMM_W-1:0]   imm_out;
  logic               imm_pfx;
  logic               pfx_err;

  // Upstream decoder / downstream consumer side.
  modport master (
    output in_valid, instruction, imm_src, out_ready,
    input  in_ready, out_valid, imm_out, imm_pfx, pfx_err
  );

  // Immediate generator side.
  modport slave (
    input  in_valid, instruction, imm_src, out_ready,
    output in_ready, out_valid, imm_out, imm_pfx, pfx_err
  );

endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with PREFIX support.
// One-deep output register with full throughput. PREFIX words accumulate
// upper immediate bits that are glued onto the next prefixable immediate.
module imm_gen_pipe #(
  parameter int INSTR_W = 16,
  parameter int IMM_W   = 16
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  localparam int PFX_W = IMM_W - 8;

  localparam logic [2:0] SRC_OPC  = 3'b000;
  localparam logic [2:0] SRC_MEM  = 3'b001;
  localparam logic [2:0] SRC_SHF  = 3'b010;
  localparam logic [2:0] SRC_ADDI = 3'b011;
  localparam logic [2:0] SRC_PFX  = 3'b100;

  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1101;

  typedef enum logic {NOPFX, PFX} state_t;

  state_t           state;
  logic [PFX_W-1:0] pfx_acc;
  logic             out_valid_q;
  logic [IMM_W-1:0] imm_q;
  logic             imm_pfx_q;
  logic             pfx_err_q;

  logic [15:0]      instr;
  logic             accept;
  logic             is_prefix;
  logic             prefixable;
  logic [IMM_W-1:0] base;
  logic [PFX_W-1:0] pfx_next;

  // Only the low 16 bits carry immediate fields.
  assign instr = bus.instruction[15:0];

  // A slot is free when the register is empty or being drained this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_prefix    = (bus.imm_src == SRC_PFX);
  assign prefixable   = (bus.imm_src == SRC_OPC) || (bus.imm_src == SRC_MEM) ||
                        (bus.imm_src == SRC_ADDI);

  // A first prefix starts from zero; later ones shift in 12 more bits and
  // let the oldest bits fall off the top of the accumulator.
  assign pfx_next = (state == PFX) ? ((pfx_acc << 12) | PFX_W'(instr[11:0]))
                                   : PFX_W'(instr[11:0]);

  assign bus.out_valid = out_valid_q;
  assign bus.imm_out   = imm_q;
  assign bus.imm_pfx   = imm_pfx_q;
  assign bus.pfx_err   = pfx_err_q;

  // Base immediate extraction selected by imm_src.
  always_comb begin
    // NOTE: default first so every path assigns base and no latch is inferred.
    base = '0;
    unique case (bus.imm_src)
      SRC_OPC: begin
        if (instr[15:12] == OP_LDI) begin
          base = {{(IMM_W-8){instr[8]}}, instr[8:1]};
        end else if (instr[15:12] == OP_JMP) begin
          base = {{(IMM_W-8){instr[11]}}, instr[11:4]};
        end
      end
      SRC_MEM:  base = {{(IMM_W-6){instr[5]}}, instr[5:0]};
      SRC_SHF:  base = IMM_W'(instr[5:3]);
      SRC_ADDI: base = {{(IMM_W-5){instr[5]}}, instr[5:1]};
      default:  base = '0;
    endcase
  end

  // Prefix state machine and output register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= NOPFX;
      pfx_acc     <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      imm_pfx_q   <= 1'b0;
      pfx_err_q   <= 1'b0;
    end else if (flush) begin
      state       <= NOPFX;
      pfx_acc     <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      imm_pfx_q   <= 1'b0;
      pfx_err_q   <= 1'b0;
    end else if (accept) begin
      if (is_prefix) begin
        // Any held result was drained to make room, so the register empties.
        state       <= PFX;
        pfx_acc     <= pfx_next;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= 1'b1;
        if (state == PFX && prefixable) begin
          imm_q     <= {pfx_acc, base[7:0]};
          imm_pfx_q <= 1'b1;
          pfx_err_q <= 1'b0;
        end else begin
          // A pending prefix is discarded by a mode that cannot use it.
          imm_q     <= base;
          imm_pfx_q <= 1'b0;
          pfx_err_q <= (state == PFX);
        end
        state   <= NOPFX;
        pfx_acc <= '0;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: the driver runs a behavioural model
// and queues expected immediates; a negedge monitor pops and compares them
// whenever the DUT hands a result to the consumer.
module tb_imm_gen_pipe;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 16;
  localparam int PFX_MOD = 1 << (IMM_W - 8);

  typedef struct {
    logic [IMM_W-1:0] imm;
    logic             pfx;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  imm_gen_pipe_if #(.INSTR_W(INSTR_W), .IMM_W(IMM_W)) bus ();

  imm_gen_pipe #(.INSTR_W(INSTR_W), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Model state.
  bit   exp_ov = 1'b0;
  bit   nxt_ov = 1'b0;
  bit   drop_q = 1'b0;
  bit   pfx_pending = 1'b0;
  int   pfx_val = 0;

  // Monitor state.
  bit          prev_stall = 1'b0;
  logic [17:0] held;

  // Random stimulus variables.
  int          r;
  logic        g_v, g_ordy, g_fl;
  logic [2:0]  g_src;
  logic [15:0] g_ins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  // Base immediate as a signed integer, straight from the field rules.
  function automatic int base_of(input logic [2:0] src, input logic [15:0] ins);
    int w;
    w = int'(ins);
    case (src)
      3'd0: begin
        if ((w >> 12) == 10) return sx((w >> 1) & 255, 8);
        if ((w >> 12) == 13) return sx((w >> 4) & 255, 8);
        return 0;
      end
      3'd1:    return sx(w & 63, 6);
      3'd2:    return (w >> 3) & 7;
      3'd3:    return sx((w >> 1) & 31, 5);
      default: return 0;
    endcase
  endfunction

  // One clock of stimulus; the model decides acceptance from its own view
  // of the output register and queues whatever the DUT should produce.
  task automatic step(input logic v, input logic [2:0] src, input logic [15:0] ins,
                      input logic ordy, input logic fl);
    bit   acc;
    int   b;
    exp_t e;
    @(posedge clk);
    #1;
    exp_ov = nxt_ov;
    if (drop_q) begin
      sb.delete();
      drop_q = 1'b0;
    end
    bus.in_valid    = v;
    bus.imm_src     = src;
    bus.instruction = ins;
    bus.out_ready   = ordy;
    flush           = fl;
    #1;
    acc = v && (!exp_ov || ordy);
    if (fl) begin
      nxt_ov      = 1'b0;
      pfx_pending = 1'b0;
      pfx_val     = 0;
      drop_q      = 1'b1;
    end else if (acc && src == 3'd4) begin
      pfx_val     = pfx_pending ? (pfx_val * 4096 + (int'(ins) & 4095)) % PFX_MOD
                                : (int'(ins) & 4095) % PFX_MOD;
      pfx_pending = 1'b1;
      nxt_ov      = 1'b0;
    end else if (acc) begin
      b = base_of(src, ins);
      if (pfx_pending && (src == 3'd0 || src == 3'd1 || src == 3'd3)) begin
        e.imm = IMM_W'(pfx_val * 256 + (b & 255));
        e.pfx = 1'b1;
        e.err = 1'b0;
      end else begin
        e.imm = IMM_W'(b);
        e.pfx = 1'b0;
        e.err = pfx_pending;
      end
      pfx_pending = 1'b0;
      pfx_val     = 0;
      sb.push_back(e);
      nxt_ov = 1'b1;
    end else begin
      nxt_ov = exp_ov && !ordy;
    end
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    sb.delete();
    exp_ov = 1'b0;
    nxt_ov = 1'b0;
    drop_q = 1'b0;
    pfx_pending = 1'b0;
    pfx_val = 0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_imm_out", 32'(bus.imm_out), 32'd0);
    check("rst_imm_pfx", 32'(bus.imm_pfx), 32'd0);
    check("rst_pfx_err", 32'(bus.pfx_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // Monitor: handshake, hold stability and scoreboard comparison.
  always @(negedge clk) begin
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("in_ready", 32'(bus.in_ready), 32'(!exp_ov || bus.out_ready));
    if (bus.out_valid) begin
      if (prev_stall) begin
        check("hold", 32'({bus.imm_out, bus.imm_pfx, bus.pfx_err}), 32'(held));
      end
      if (bus.out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("imm_out", 32'(bus.imm_out), 32'(mon_e.imm));
          check("imm_pfx", 32'(bus.imm_pfx), 32'(mon_e.pfx));
          check("pfx_err", 32'(bus.pfx_err), 32'(mon_e.err));
        end
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    held       = {bus.imm_out, bus.imm_pfx, bus.pfx_err};
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.imm_src     = 3'd0;
    bus.instruction = 16'h0000;
    bus.out_ready   = 1'b0;
    do_reset();

    // LDI / JMP opcode select.
    step(1, 3'd0, 16'hA1FE, 1, 0);
    step(1, 3'd0, 16'hD7F0, 1, 0);
    // Back-to-back memory and ADDI immediates.
    step(1, 3'd1, 16'h0020, 1, 0);
    step(1, 3'd3, 16'h001E, 1, 0);
    // Prefix glued onto the next immediate, then a plain one.
    step(1, 3'd4, 16'hF0AB, 1, 0);
    step(1, 3'd1, 16'h0005, 1, 0);
    step(1, 3'd1, 16'h0005, 1, 0);
    // Prefix dropped by SHIFT mode, then a clean word.
    step(1, 3'd4, 16'hF0AB, 1, 0);
    step(1, 3'd2, 16'h0028, 1, 0);
    step(1, 3'd1, 16'h0005, 1, 0);
    // Back-pressure for three cycles with a word waiting.
    step(1, 3'd1, 16'h0030, 1, 0);
    repeat (3) step(1, 3'd3, 16'h001E, 0, 0);
    step(1, 3'd3, 16'h001E, 1, 0);
    step(0, 3'd0, 16'h0000, 1, 0);
    // Prefix lost to an async reset.
    step(1, 3'd4, 16'hF0AB, 1, 0);
    do_reset();
    step(1, 3'd1, 16'h0005, 1, 0);
    // Prefix lost to a flush; the word presented with flush is dropped.
    step(1, 3'd4, 16'hF0AB, 1, 0);
    step(1, 3'd1, 16'h0011, 1, 1);
    step(1, 3'd1, 16'h0005, 1, 0);
    // Flush while a result is stalled.
    step(0, 3'd0, 16'h0000, 1, 0);
    step(1, 3'd1, 16'h0015, 0, 0);
    step(0, 3'd0, 16'h0000, 0, 1);
    step(0, 3'd0, 16'h0000, 1, 0);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        g_v    = ($urandom_range(0, 99) < 80);
        g_src  = ($urandom_range(0, 4) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
        g_ins  = 16'($urandom);
        if (g_src == 3'd0 && $urandom_range(0, 2) != 0) begin
          g_ins[15:12] = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hD;
        end
        g_ordy = ($urandom_range(0, 99) < 70);
        g_fl   = ($urandom_range(0, 99) < 3);
        step(g_v, g_src, g_ins, g_ordy, g_fl);
      end
    end

    // Drain and confirm nothing is left outstanding.
    repeat (4) step(0, 3'd0, 16'h0000, 1, 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
